// File: rtl/rv32_mem_pkg.sv
// Shared encodings for the MEM-stage data-memory path: RV32 load/store width codes,
// access-sequencer states and byte-lane enable patterns.
package rv32_mem_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [3:0] BE_BYTE = 4'b0001;
  localparam logic [3:0] BE_HALF = 4'b0011;
  localparam logic [3:0] BE_WORD = 4'b1111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2
  } size_t;

  // Stores only know SB/SH as narrow; loads also treat the unsigned codes as narrow.
  function automatic size_t access_size(input logic [2:0] f3, input logic is_write);
    size_t sz;
    sz = SZ_WORD;
    if (is_write) begin
      if (f3 == F3_B)      sz = SZ_BYTE;
      else if (f3 == F3_H) sz = SZ_HALF;
    end else begin
      if (f3 == F3_B || f3 == F3_BU)      sz = SZ_BYTE;
      else if (f3 == F3_H || f3 == F3_HU) sz = SZ_HALF;
    end
    return sz;
  endfunction

endpackage

// File: rtl/mem_load_align.sv
// Picks the addressed byte/half out of a read word and sign- or zero-extends it.
module mem_load_align
  import rv32_mem_pkg::*;
(
  input  logic [31:0] i_rdata,
  input  logic [2:0]  i_func3,
  input  logic [1:0]  i_addr_lo,
  output logic [31:0] o_data
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    w_byte = i_rdata[7:0];
    case (i_addr_lo)
      2'd1:    w_byte = i_rdata[15:8];
      2'd2:    w_byte = i_rdata[23:16];
      2'd3:    w_byte = i_rdata[31:24];
      default: w_byte = i_rdata[7:0];
    endcase
  end

  assign w_half = i_addr_lo[1] ? i_rdata[31:16] : i_rdata[15:0];

  always_comb begin
    o_data = i_rdata;
    case (i_func3)
      F3_B:    o_data = {{24{w_byte[7]}}, w_byte};
      F3_H:    o_data = {{16{w_half[15]}}, w_half};
      F3_BU:   o_data = {24'd0, w_byte};
      F3_HU:   o_data = {16'd0, w_half};
      default: o_data = i_rdata;
    endcase
  end

endmodule

// File: rtl/dmem_access_ctrl.sv
// MEM-stage data-memory sequencer: req/ack handshake, lane alignment, load extraction, pipeline stall.
// Optional MISALIGN_TRAP_EN: misaligned half/word accesses skip the bus and raise MISALIGN.
module dmem_access_ctrl
  import rv32_mem_pkg::*;
#(
  parameter int ADDR_WIDTH     = 32,
  parameter int WAIT_CNT_WIDTH = 8
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic                      MEM_MEM_READ,
  input  logic                      MEM_MEM_WRITE,
  input  logic [2:0]                MEM_FUNC3,
  input  logic [31:0]               MEM_ALU_RESULT,
  input  logic [31:0]               MEM_READ_DATA2,
  output logic                      DMEM_REQ,
  output logic                      DMEM_WE,
  output logic [ADDR_WIDTH-1:0]     DMEM_ADDR,
  output logic [31:0]               DMEM_WDATA,
  output logic [3:0]                DMEM_BYTE_EN,
  input  logic                      DMEM_ACK,
  input  logic [31:0]               DMEM_RDATA,
  output logic [31:0]               LOAD_DATA,
  output logic                      PIPE_STALL,
  output logic [WAIT_CNT_WIDTH-1:0] LAST_WAIT_CYCLES
`ifdef MISALIGN_TRAP_EN
  ,
  output logic                      MISALIGN
`endif
);

  state_t                    r_state;
  logic                      r_req;
  logic                      r_we;
  logic                      r_is_load;
  logic [ADDR_WIDTH-1:0]     r_addr;
  logic [31:0]               r_wdata;
  logic [3:0]                r_be;
  logic [2:0]                r_func3;
  logic [1:0]                r_addr_lo;
  logic [31:0]               r_load_data;
  logic [WAIT_CNT_WIDTH-1:0] r_wait_cnt;
  logic [WAIT_CNT_WIDTH-1:0] r_last_wait;

  logic        w_access;
  size_t       w_size;
  logic [3:0]  w_be;
  logic [31:0] w_wdata;
  logic [31:0] w_load_aligned;

  assign w_access = MEM_MEM_READ | MEM_MEM_WRITE;
  assign w_size   = access_size(MEM_FUNC3, MEM_MEM_WRITE);

  // Loads always fetch the whole word; only stores narrow the lanes.
  always_comb begin
    w_be    = BE_WORD;
    w_wdata = MEM_READ_DATA2;
    if (MEM_MEM_WRITE) begin
      case (w_size)
        SZ_BYTE: begin
          w_be    = BE_BYTE << MEM_ALU_RESULT[1:0];
          w_wdata = {4{MEM_READ_DATA2[7:0]}};
        end
        SZ_HALF: begin
          w_be    = BE_HALF << {MEM_ALU_RESULT[1], 1'b0};
          w_wdata = {2{MEM_READ_DATA2[15:0]}};
        end
        default: ;
      endcase
    end
  end

`ifdef MISALIGN_TRAP_EN
  logic w_misalign;
  logic r_misalign;
  assign w_misalign = ((w_size == SZ_HALF) && MEM_ALU_RESULT[0]) ||
                      ((w_size == SZ_WORD) && (MEM_ALU_RESULT[1:0] != 2'b00));
  assign MISALIGN   = r_misalign;
`endif

  mem_load_align u_load_align (
    .i_rdata   (DMEM_RDATA),
    .i_func3   (r_func3),
    .i_addr_lo (r_addr_lo),
    .o_data    (w_load_aligned)
  );

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state     <= ST_IDLE;
      r_req       <= 1'b0;
      r_we        <= 1'b0;
      r_is_load   <= 1'b0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_be        <= '0;
      r_func3     <= '0;
      r_addr_lo   <= '0;
      r_load_data <= '0;
      r_wait_cnt  <= '0;
      r_last_wait <= '0;
`ifdef MISALIGN_TRAP_EN
      r_misalign  <= 1'b0;
`endif
    end else begin
`ifdef MISALIGN_TRAP_EN
      r_misalign <= 1'b0;
`endif
      case (r_state)
        ST_IDLE: begin
          if (w_access) begin
`ifdef MISALIGN_TRAP_EN
            if (w_misalign) begin
              r_state     <= ST_DONE;
              r_misalign  <= 1'b1;
              r_load_data <= '0;
            end else
`endif
            begin
              r_state    <= ST_WAIT;
              r_req      <= 1'b1;
              r_we       <= MEM_MEM_WRITE;
              r_is_load  <= ~MEM_MEM_WRITE;
              r_addr     <= {MEM_ALU_RESULT[ADDR_WIDTH-1:2], 2'b00};
              r_wdata    <= w_wdata;
              r_be       <= w_be;
              r_func3    <= MEM_FUNC3;
              r_addr_lo  <= MEM_ALU_RESULT[1:0];
              r_wait_cnt <= '0;
            end
          end
        end
        ST_WAIT: begin
          if (DMEM_ACK) begin
            r_req       <= 1'b0;
            r_last_wait <= r_wait_cnt;
            r_state     <= ST_DONE;
            if (r_is_load) r_load_data <= w_load_aligned;
          end else if (r_wait_cnt != {WAIT_CNT_WIDTH{1'b1}}) begin
            r_wait_cnt <= r_wait_cnt + 1'b1;
          end
        end
        // Single bubble so the still-present instruction is not issued twice.
        ST_DONE: r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign DMEM_REQ         = r_req;
  assign DMEM_WE          = r_we;
  assign DMEM_ADDR        = r_addr;
  assign DMEM_WDATA       = r_wdata;
  assign DMEM_BYTE_EN     = r_be;
  assign LOAD_DATA        = r_load_data;
  assign LAST_WAIT_CYCLES = r_last_wait;
  assign PIPE_STALL       = ((r_state == ST_IDLE) && w_access) || (r_state == ST_WAIT);

endmodule
